vx_mem_port_model: RTL and testbench

- Synthesizable multi-port memory responder that terminates the flattened L1 memory bus of vx_top in simulation and FPGA harnesses.
- Each port has an independent in-order request queue with configurable fixed latency, backpressure and tag return.
- All ports share one word-addressed storage array.
- Generalises the single fixed memory hookup to N ports with parametrised width, depth, latency and outstanding-request count.

---
 rtl/vx_mem_port_model.sv | 123 ++++++++++++
 tb/tb_vx_mem_port_model.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_port_model.sv
// Multi-port memory responder: shared word-addressed storage with per-port in-order read
// queues that return data a fixed number of cycles after accept.
module vx_mem_port_model #(
  parameter int unsigned NPORTS      = 1,
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NPORTS-1:0]                  mem_req_valid,
  output logic [NPORTS-1:0]                  mem_req_ready,
  input  logic [NPORTS-1:0]                  mem_req_rw,
  input  logic [NPORTS*ADDR_WIDTH-1:0]       mem_req_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]       mem_req_data,
  input  logic [NPORTS*(DATA_WIDTH/8)-1:0]   mem_req_byteen,
  input  logic [NPORTS*TAG_WIDTH-1:0]        mem_req_tag,
  output logic [NPORTS-1:0]                  mem_rsp_valid,
  input  logic [NPORTS-1:0]                  mem_rsp_ready,
  output logic [NPORTS*DATA_WIDTH-1:0]       mem_rsp_data,
  output logic [NPORTS*TAG_WIDTH-1:0]        mem_rsp_tag,
  output logic                               busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CD_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]      idx [NPORTS];
  logic [NPORTS-1:0]     wr_en;
  logic [NPORTS-1:0]     nonempty_d;
  logic                  busy_q;
  logic                  unused_addr;

  assign unused_addr = ^mem_req_addr;

  // Ascending port order makes the highest enabled port win each byte lane.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (wr_en[p]) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (mem_req_byteen[p*NBYTES + b]) begin
            mem[idx[p]][b*8 +: 8] <= mem_req_data[p*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]  q_tag  [QUEUE_DEPTH];
    logic [CD_W-1:0]       q_cd   [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_q, accept, push, pop, head_valid;

    assign idx[p]     = mem_req_addr[p*ADDR_WIDTH +: IDX_W];
    assign accept     = reset_n & mem_req_valid[p] & ready_q;
    assign wr_en[p]   = accept & mem_req_rw[p];
    assign push       = accept & ~mem_req_rw[p];
    assign head_valid = (count_q != '0) && (q_cd[rd_ptr_q] == '0);
    assign pop        = head_valid & mem_rsp_ready[p];

    always_comb begin
      count_d = count_q;
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    assign nonempty_d[p] = (count_d != '0);

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        ready_q  <= 1'b0;
      end else begin
        count_q <= count_d;
        ready_q <= (count_d < DEPTH_C);
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end

    // Payload is not reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - CD_W'(1);
      end
      if (push) begin
        q_data[wr_ptr_q] <= mem[idx[p]];
        q_tag[wr_ptr_q]  <= mem_req_tag[p*TAG_WIDTH +: TAG_WIDTH];
        q_cd[wr_ptr_q]   <= CD_INIT;
      end
    end

    assign mem_req_ready[p] = ready_q;
    assign mem_rsp_valid[p] = head_valid;
    assign mem_rsp_data[p*DATA_WIDTH +: DATA_WIDTH] = head_valid ? q_data[rd_ptr_q] : '0;
    assign mem_rsp_tag[p*TAG_WIDTH +: TAG_WIDTH]    = head_valid ? q_tag[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) busy_q <= 1'b0;
    else          busy_q <= |nonempty_d;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_vx_mem_port_model.sv
// Directed bench: a 2-port, latency-4 instance for the main function and a 4-port,
// latency-1 instance for per-port independence.
module tb_vx_mem_port_model;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: NPORTS=2, DATA_WIDTH=64, LATENCY=4, QUEUE_DEPTH=8
  logic [1:0]   a_valid = '0, a_rw = '0, a_rsp_ready = 2'b11;
  logic [1:0]   a_ready, a_rsp_valid;
  logic [25:0]  a_addr [2];
  logic [63:0]  a_wdata [2];
  logic [7:0]   a_be [2];
  logic [7:0]   a_tag [2];
  logic [127:0] a_rdata;
  logic [15:0]  a_rtag;
  logic         a_busy;

  // Instance B: NPORTS=4, DATA_WIDTH=32, LATENCY=1, QUEUE_DEPTH=4
  logic [3:0]   b_valid = '0, b_rw = '0, b_rsp_ready = 4'hF;
  logic [3:0]   b_ready, b_rsp_valid;
  logic [7:0]   b_addr [4];
  logic [31:0]  b_wdata [4];
  logic [3:0]   b_be [4];
  logic [3:0]   b_tag [4];
  logic [127:0] b_rdata;
  logic [15:0]  b_rtag;
  logic         b_busy;

  vx_mem_port_model #(
    .NPORTS(2), .ADDR_WIDTH(26), .DATA_WIDTH(64), .TAG_WIDTH(8),
    .MEM_WORDS(4096), .LATENCY(4), .QUEUE_DEPTH(8)
  ) u_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (a_valid),
    .mem_req_ready  (a_ready),
    .mem_req_rw     (a_rw),
    .mem_req_addr   ({a_addr[1], a_addr[0]}),
    .mem_req_data   ({a_wdata[1], a_wdata[0]}),
    .mem_req_byteen ({a_be[1], a_be[0]}),
    .mem_req_tag    ({a_tag[1], a_tag[0]}),
    .mem_rsp_valid  (a_rsp_valid),
    .mem_rsp_ready  (a_rsp_ready),
    .mem_rsp_data   (a_rdata),
    .mem_rsp_tag    (a_rtag),
    .busy           (a_busy)
  );

  vx_mem_port_model #(
    .NPORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TAG_WIDTH(4),
    .MEM_WORDS(256), .LATENCY(1), .QUEUE_DEPTH(4)
  ) u_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (b_valid),
    .mem_req_ready  (b_ready),
    .mem_req_rw     (b_rw),
    .mem_req_addr   ({b_addr[3], b_addr[2], b_addr[1], b_addr[0]}),
    .mem_req_data   ({b_wdata[3], b_wdata[2], b_wdata[1], b_wdata[0]}),
    .mem_req_byteen ({b_be[3], b_be[2], b_be[1], b_be[0]}),
    .mem_req_tag    ({b_tag[3], b_tag[2], b_tag[1], b_tag[0]}),
    .mem_rsp_valid  (b_rsp_valid),
    .mem_rsp_ready  (b_rsp_ready),
    .mem_rsp_data   (b_rdata),
    .mem_rsp_tag    (b_rtag),
    .busy           (b_busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input int p, input logic [25:0] addr, input logic [63:0] d,
                         input logic [7:0] be);
    a_valid[p] = 1'b1; a_rw[p] = 1'b1; a_addr[p] = addr; a_wdata[p] = d; a_be[p] = be;
    cyc();
    a_valid[p] = 1'b0; a_rw[p] = 1'b0;
  endtask

  // Issue a read, wait the fixed latency, check, and let it pop.
  task automatic a_read(input string name, input int p, input logic [25:0] addr,
                        input logic [7:0] tag, input logic [63:0] exp);
    a_valid[p] = 1'b1; a_rw[p] = 1'b0; a_addr[p] = addr; a_tag[p] = tag;
    cyc();
    a_valid[p] = 1'b0;
    repeat (3) cyc();
    chk({name, "_valid"}, 64'(a_rsp_valid[p]), 64'd1);
    chk({name, "_data"}, a_rdata[p*64 +: 64], exp);
    chk({name, "_tag"}, 64'(a_rtag[p*8 +: 8]), 64'(tag));
    cyc();
  endtask

  initial begin
    int acc;
    for (int p = 0; p < 2; p++) begin
      a_addr[p] = '0; a_wdata[p] = '0; a_be[p] = '0; a_tag[p] = '0;
    end
    for (int p = 0; p < 4; p++) begin
      b_addr[p] = '0; b_wdata[p] = '0; b_be[p] = '0; b_tag[p] = '0;
    end

    // Reset for two cycles, check outputs in reset and in the cycle after it.
    cyc(); cyc();
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    reset_n = 1'b1;
    chk("post_rst_ready", 64'(a_ready), 64'd0);
    chk("post_rst_rdata", a_rdata[63:0], 64'd0);
    chk("post_rst_rtag", 64'(a_rtag), 64'd0);
    cyc();
    chk("ready_up", 64'(a_ready), 64'h3);

    // Write then read with exact latency.
    a_write(0, 26'h10, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    a_valid[0] = 1'b1; a_addr[0] = 26'h10; a_tag[0] = 8'h3;
    cyc();
    a_valid[0] = 1'b0;
    chk("busy_after_rd", 64'(a_busy), 64'd1);
    cyc(); cyc();
    chk("lat_early", 64'(a_rsp_valid[0]), 64'd0);
    cyc();
    chk("lat_valid", 64'(a_rsp_valid[0]), 64'd1);
    chk("lat_data", a_rdata[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
    chk("lat_tag", 64'(a_rtag[7:0]), 64'h3);
    cyc();
    chk("lat_popped", 64'(a_rsp_valid[0]), 64'd0);
    chk("busy_fall", 64'(a_busy), 64'd0);

    // Byte enables.
    a_write(0, 26'h30, 64'h0, 8'hFF);
    a_write(0, 26'h30, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
    a_read("be_lane0", 0, 26'h30, 8'h4, 64'h0000_0000_0000_00FF);
    a_write(0, 26'h30, 64'h1122_3344_5566_7788, 8'h84);
    a_read("be_sparse", 0, 26'h30, 8'h5, 64'h1100_0000_0066_00FF);

    // Same-edge write conflicts: highest port wins per lane.
    a_valid = 2'b11; a_rw = 2'b11;
    a_addr[0] = 26'h20; a_wdata[0] = 64'h1111_1111_1111_1111; a_be[0] = 8'hFF;
    a_addr[1] = 26'h20; a_wdata[1] = 64'h2222_2222_2222_2222; a_be[1] = 8'hFF;
    cyc();
    a_addr[0] = 26'h21; a_addr[1] = 26'h21; a_be[1] = 8'h0F;
    cyc();
    a_valid = 2'b00; a_rw = 2'b00;
    a_read("conflict_full", 1, 26'h20, 8'h6, 64'h2222_2222_2222_2222);
    a_read("conflict_lane", 1, 26'h21, 8'h7, 64'h1111_1111_2222_2222);

    // Aliasing, then read-before-write on one edge.
    a_write(0, 26'h1005, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    a_read("alias", 0, 26'h0005, 8'h8, 64'hDEAD_BEEF_CAFE_F00D);
    a_valid = 2'b11; a_rw = 2'b10;
    a_addr[0] = 26'h0005; a_tag[0] = 8'h9;
    a_addr[1] = 26'h2005; a_wdata[1] = 64'h0123_4567_89AB_CDEF; a_be[1] = 8'hFF;
    cyc();
    a_valid = 2'b00; a_rw = 2'b00;
    repeat (3) cyc();
    chk("rbw_old_data", a_rdata[63:0], 64'hDEAD_BEEF_CAFE_F00D);
    chk("rbw_tag", 64'(a_rtag[7:0]), 64'h9);
    cyc();
    a_read("rbw_new", 0, 26'h0005, 8'hA, 64'h0123_4567_89AB_CDEF);

    // Backpressure: ten reads against an eight-deep queue.
    for (int i = 0; i < 10; i++) a_write(0, 26'h40 + 26'(i), 64'h100 + 64'(i), 8'hFF);
    a_rsp_ready[0] = 1'b0;
    acc = 0;
    a_valid[0] = 1'b1; a_rw[0] = 1'b0;
    for (int n = 0; n < 12; n++) begin
      a_addr[0] = 26'h40 + 26'(acc);
      a_tag[0]  = 8'(acc);
      if (a_ready[0]) begin
        cyc();
        acc++;
      end else begin
        cyc();
      end
    end
    a_valid[0] = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd8);
    chk("bp_ready_low", 64'(a_ready[0]), 64'd0);
    chk("bp_stall_tag0", 64'(a_rtag[7:0]), 64'h0);
    cyc(); cyc();
    chk("bp_stall_valid", 64'(a_rsp_valid[0]), 64'd1);
    chk("bp_stall_tag", 64'(a_rtag[7:0]), 64'h0);
    chk("bp_stall_data", a_rdata[63:0], 64'h100);
    chk("bp_busy", 64'(a_busy), 64'd1);
    a_rsp_ready[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_drain_valid", 64'(a_rsp_valid[0]), 64'd1);
      chk("bp_drain_tag", 64'(a_rtag[7:0]), 64'(k));
      chk("bp_drain_data", a_rdata[63:0], 64'h100 + 64'(k));
      cyc();
      if (k == 0) chk("bp_ready_back", 64'(a_ready[0]), 64'd1);
    end
    chk("bp_empty", 64'(a_rsp_valid[0]), 64'd0);
    chk("bp_busy_fall", 64'(a_busy), 64'd0);

    // Reset with three reads in flight.
    a_valid[0] = 1'b1; a_rw[0] = 1'b0; a_addr[0] = 26'h10;
    for (int i = 1; i <= 3; i++) begin
      a_tag[0] = 8'(i);
      cyc();
    end
    a_valid[0] = 1'b0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mid_rst_valid", 64'(a_rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(a_busy), 64'd0);
    chk("mid_rst_ready", 64'(a_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("mid_rst_no_stale", 64'(a_rsp_valid), 64'd0);
    end

    // Instance B: latency 1, four independent ports, port 2 stalled.
    for (int p = 0; p < 4; p++) begin
      b_addr[p] = 8'(p); b_wdata[p] = 32'hB000_0000 + 32'(p); b_be[p] = 4'hF;
    end
    b_valid = 4'hF; b_rw = 4'hF;
    cyc();
    b_rw = 4'h0;
    for (int p = 0; p < 4; p++) b_tag[p] = 4'(p);
    b_rsp_ready = 4'b1011;
    cyc();
    b_valid = 4'h0;
    chk("b_all_valid", 64'(b_rsp_valid), 64'hF);
    for (int p = 0; p < 4; p++) begin
      chk("b_data", 64'(b_rdata[p*32 +: 32]), 64'hB000_0000 + 64'(p));
      chk("b_tag", 64'(b_rtag[p*4 +: 4]), 64'(p));
    end
    cyc();
    chk("b_stall_valid", 64'(b_rsp_valid), 64'b0100);
    chk("b_stall_data", 64'(b_rdata[95:64]), 64'hB000_0002);
    b_valid[0] = 1'b1; b_addr[0] = 8'h1; b_tag[0] = 4'h9;
    cyc();
    b_valid[0] = 1'b0;
    chk("b_indep_valid", 64'(b_rsp_valid), 64'b0101);
    chk("b_indep_data", 64'(b_rdata[31:0]), 64'hB000_0001);
    chk("b_indep_tag", 64'(b_rtag[3:0]), 64'h9);
    b_rsp_ready = 4'hF;
    cyc();
    chk("b_drained", 64'(b_rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
